imem_resp_32: RTL and testbench

- Instruction-memory responder: the other end of the fetch interface driven by the 32-bit PC unit.
- Two phases:
  - LOAD: accepts program words from a testbench/boot source over a valid/ready stream.
  - RUN: returns a combinational instruction word for each fetch address, as the single-cycle datapath requires.
- Flags misaligned and unloaded fetches.
- Drives `run`, which the core uses to hold the PC until the program is loaded.

---
 rtl/imem_resp_32_if.sv | 42 ++++
 rtl/imem_resp_32.sv | 100 ++++++++++
 tb/tb_imem_resp_32.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/imem_resp_32_if.sv
// Fetch and program-load bundle between a core/boot source and the
// instruction-memory responder.
interface imem_resp_32_if #(
    parameter int unsigned DEPTH_LOG2 = 8
);
    logic [31:0]         addr;
    logic [31:0]         instruction;
    logic                load_valid;
    logic                load_ready;
    logic [31:0]         load_data;
    logic                load_last;
    logic                run;
    logic                fault;
    logic                fault_sticky;
    logic [DEPTH_LOG2:0] load_count;

    modport master (
        output addr,
        output load_valid,
        output load_data,
        output load_last,
        input  instruction,
        input  load_ready,
        input  run,
        input  fault,
        input  fault_sticky,
        input  load_count
    );

    modport slave (
        input  addr,
        input  load_valid,
        input  load_data,
        input  load_last,
        output instruction,
        output load_ready,
        output run,
        output fault,
        output fault_sticky,
        output load_count
    );
endinterface

// File: rtl/imem_resp_32.sv
// Instruction-memory responder: streams a program in during LOAD,
// then serves combinational fetches during RUN.
module imem_resp_32 #(
    parameter int unsigned DEPTH_LOG2 = 8,
    parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
    input logic           clk,
    input logic           reset,
    imem_resp_32_if.slave bus
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic {
        S_LOAD,
        S_RUN
    } state_t;

    state_t              r_state;
    logic                r_run;
    logic                r_load_ready;
    logic                r_fault_sticky;
    logic [DEPTH_LOG2:0] r_load_count;
    logic [31:0]         r_mem [DEPTH];

    logic                  w_xfer;
    logic                  w_done;
    logic [DEPTH_LOG2:0]   w_count_nxt;
    logic [DEPTH_LOG2-1:0] w_index;
    logic                  w_aligned;
    logic                  w_in_range;
    logic                  w_loaded;
    logic                  w_valid;
    logic                  w_fault;

    assign w_xfer      = bus.load_valid & r_load_ready;
    assign w_count_nxt = r_load_count + 1'b1;
    assign w_done      = bus.load_last | (w_count_nxt == FULL);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_LOAD;
            r_run        <= 1'b0;
            r_load_ready <= 1'b1;
            r_load_count <= '0;
        end else begin
            unique case (r_state)
                S_LOAD: begin
                    if (w_xfer) begin
                        r_load_count <= w_count_nxt;
                        if (w_done) begin
                            r_state      <= S_RUN;
                            r_run        <= 1'b1;
                            r_load_ready <= 1'b0;
                        end
                    end
                end
                S_RUN: begin
                    r_state      <= S_RUN;
                    r_run        <= 1'b1;
                    r_load_ready <= 1'b0;
                end
                default: begin
                    r_state      <= S_LOAD;
                    r_run        <= 1'b0;
                    r_load_ready <= 1'b1;
                end
            endcase
        end
    end

    // Array is never cleared; the load_count bound hides stale words.
    always_ff @(posedge clk) begin
        if (!reset && w_xfer) begin
            r_mem[r_load_count[DEPTH_LOG2-1:0]] <= bus.load_data;
        end
    end

    assign w_index    = bus.addr[DEPTH_LOG2+1:2];
    assign w_aligned  = (bus.addr[1:0] == 2'b00);
    assign w_in_range = ((bus.addr >> (DEPTH_LOG2 + 2)) == 32'd0);
    assign w_loaded   = ({1'b0, w_index} < r_load_count);
    assign w_valid    = w_aligned & w_in_range & w_loaded;
    assign w_fault    = r_run & ~w_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fault_sticky <= 1'b0;
        end else if (w_fault) begin
            r_fault_sticky <= 1'b1;
        end
    end

    assign bus.instruction  = (r_run & w_valid) ? r_mem[w_index] : NOP_WORD;
    assign bus.fault        = w_fault;
    assign bus.fault_sticky = r_fault_sticky;
    assign bus.run          = r_run;
    assign bus.load_ready   = r_load_ready;
    assign bus.load_count   = r_load_count;
endmodule

// File: tb/tb_imem_resp_32.sv
// Directed bench for imem_resp_32: load, fetch, fault, overflow,
// mid-load reset and gapped handshake sequences.
module tb_imem_resp_32;
    logic clk;
    logic reset;
    int   n_tests;
    int   n_failed;

    imem_resp_32_if #(.DEPTH_LOG2(8)) bus ();

    imem_resp_32 #(
        .DEPTH_LOG2(8),
        .NOP_WORD  (32'h0000_0000)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fetch(input string tag, input logic [31:0] a,
                         input logic [31:0] exp_i, input logic exp_f);
        bus.addr = a;
        #1;
        chk({tag, "_instr"}, 64'(bus.instruction), 64'(exp_i));
        chk({tag, "_fault"}, 64'(bus.fault), 64'(exp_f));
    endtask

    task automatic xfer(input logic [31:0] d, input logic last);
        bus.load_valid = 1'b1;
        bus.load_data  = d;
        bus.load_last  = last;
        tick();
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
    endtask

    initial begin
        n_tests        = 0;
        n_failed       = 0;
        reset          = 1'b1;
        bus.addr       = 32'h0;
        bus.load_valid = 1'b0;
        bus.load_data  = 32'h0;
        bus.load_last  = 1'b0;
        tick();
        chk("rst_run", 64'(bus.run), 64'd0);
        chk("rst_ready", 64'(bus.load_ready), 64'd1);
        chk("rst_count", 64'(bus.load_count), 64'd0);
        chk("rst_fault", 64'(bus.fault), 64'd0);
        chk("rst_sticky", 64'(bus.fault_sticky), 64'd0);
        chk("rst_instr", 64'(bus.instruction), 64'h0);
        reset = 1'b0;

        // Three-word program
        xfer(32'h2008_0005, 1'b0);
        xfer(32'h2009_0003, 1'b0);
        chk("p3_run_mid", 64'(bus.run), 64'd0);
        fetch("p3_load_nop", 32'h0, 32'h0, 1'b0);
        xfer(32'h0109_5020, 1'b1);
        chk("p3_run", 64'(bus.run), 64'd1);
        chk("p3_count", 64'(bus.load_count), 64'd3);
        chk("p3_ready", 64'(bus.load_ready), 64'd0);
        fetch("p3_a0", 32'h0, 32'h2008_0005, 1'b0);
        fetch("p3_a4", 32'h4, 32'h2009_0003, 1'b0);
        fetch("p3_a8", 32'h8, 32'h0109_5020, 1'b0);
        chk("p3_sticky0", 64'(bus.fault_sticky), 64'd0);

        // Unloaded index and sticky latch
        fetch("p3_aC", 32'hC, 32'h0, 1'b1);
        tick();
        chk("sticky_set", 64'(bus.fault_sticky), 64'd1);
        fetch("p3_a0_again", 32'h0, 32'h2008_0005, 1'b0);
        tick();
        chk("sticky_hold", 64'(bus.fault_sticky), 64'd1);
        fetch("misalign", 32'h2, 32'h0, 1'b1);
        fetch("oor_400", 32'h400, 32'h0, 1'b1);
        fetch("oor_hi", 32'h8000_0000, 32'h0, 1'b1);

        // Fill all 256 words without load_last
        bus.addr = 32'h0;
        reset    = 1'b1;
        tick();
        reset = 1'b0;
        chk("fill_sticky_clr", 64'(bus.fault_sticky), 64'd0);
        for (int i = 0; i < 255; i++) begin
            xfer(32'(i), 1'b0);
        end
        chk("fill_run_255", 64'(bus.run), 64'd0);
        chk("fill_cnt_255", 64'(bus.load_count), 64'd255);
        xfer(32'd255, 1'b0);
        chk("fill_run", 64'(bus.run), 64'd1);
        chk("fill_count", 64'(bus.load_count), 64'd256);
        chk("fill_ready", 64'(bus.load_ready), 64'd0);
        xfer(32'hDEAD_BEEF, 1'b1);
        chk("fill_257_cnt", 64'(bus.load_count), 64'd256);
        fetch("fill_3FC", 32'h3FC, 32'h0000_00FF, 1'b0);
        fetch("fill_000", 32'h0, 32'h0, 1'b0);
        fetch("fill_200", 32'h200, 32'h0000_0080, 1'b0);
        fetch("fill_400", 32'h400, 32'h0, 1'b1);

        // Reset mid-load, simultaneous with a transfer
        bus.addr = 32'h0;
        reset    = 1'b1;
        tick();
        reset = 1'b0;
        xfer(32'hAAAA_AAAA, 1'b0);
        xfer(32'hBBBB_BBBB, 1'b0);
        chk("mid_cnt2", 64'(bus.load_count), 64'd2);
        reset          = 1'b1;
        bus.load_valid = 1'b1;
        bus.load_data  = 32'hCCCC_CCCC;
        tick();
        reset          = 1'b0;
        bus.load_valid = 1'b0;
        chk("mid_count", 64'(bus.load_count), 64'd0);
        chk("mid_run", 64'(bus.run), 64'd0);
        chk("mid_ready", 64'(bus.load_ready), 64'd1);
        xfer(32'h1111_1111, 1'b1);
        chk("mid_run1", 64'(bus.run), 64'd1);
        chk("mid_cnt1", 64'(bus.load_count), 64'd1);
        fetch("mid_a0", 32'h0, 32'h1111_1111, 1'b0);
        fetch("mid_stale", 32'h4, 32'h0, 1'b1);

        // Gapped handshake: idle cycle carries load_last but no valid
        bus.addr = 32'h0;
        reset    = 1'b1;
        tick();
        reset = 1'b0;
        xfer(32'h1234_5678, 1'b0);
        bus.load_valid = 1'b0;
        bus.load_data  = 32'hFFFF_FFFF;
        bus.load_last  = 1'b1;
        tick();
        bus.load_last = 1'b0;
        chk("gap_cnt", 64'(bus.load_count), 64'd1);
        chk("gap_run", 64'(bus.run), 64'd0);
        xfer(32'h9ABC_DEF0, 1'b1);
        chk("gap_cnt2", 64'(bus.load_count), 64'd2);
        chk("gap_run2", 64'(bus.run), 64'd1);
        fetch("gap_a0", 32'h0, 32'h1234_5678, 1'b0);
        fetch("gap_a4", 32'h4, 32'h9ABC_DEF0, 1'b0);
        fetch("gap_a8", 32'h8, 32'h0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end
endmodule
